// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
//
// Multi-cycle shifter: performs a full shift/rotate by a SHAMT_BITS-wide amount
// by applying a single-bit step to an accumulator once per clock. It is the
// low-area alternative to a barrel shifter. One operation is in flight at a
// time (start/ready handshake). Completion is signalled by a one-cycle done
// pulse, and the result stays on data_out until the next accepted start.
//
// Ports:
//   clock     in   1           rising-edge clock
//   reset     in   1           synchronous active-high reset
//   start     in   1           request, accepted only while ready=1
//   op        in   2           00 sll, 01 srl, 10 sra, 11 rotate left
//   data_in   in   WIDTH       operand, sampled on the accepting edge
//   shamt     in   SHAMT_BITS  shift amount, sampled on the accepting edge
//   data_out  out  WIDTH       result register
//   ready     out  1           high in IDLE
//   busy      out  1           high in SHIFT and DONE
//   done      out  1           one-cycle completion pulse
// -----------------------------------------------------------------------------
module shift_sequencer #(
    parameter int WIDTH      = 32,
    parameter int SHAMT_BITS = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [WIDTH-1:0]      data_in,
    input  logic [SHAMT_BITS-1:0] shamt,
    output logic [WIDTH-1:0]      data_out,
    output logic                  ready,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    localparam logic [SHAMT_BITS-1:0] CNT_ZERO = {SHAMT_BITS{1'b0}};
    localparam logic [SHAMT_BITS-1:0] CNT_ONE  = SHAMT_BITS'(1);

    // One bit position of the selected operation.
    function automatic logic [WIDTH-1:0] step_one(
        input logic [1:0]       sel,
        input logic [WIDTH-1:0] val
    );
        logic [WIDTH-1:0] res;
        case (sel)
            OP_SLL:  res = {val[WIDTH-2:0], 1'b0};
            OP_SRL:  res = {1'b0, val[WIDTH-1:1]};
            OP_SRA:  res = {val[WIDTH-1], val[WIDTH-1:1]};
            OP_ROL:  res = {val[WIDTH-2:0], val[WIDTH-1]};
            default: res = val;
        endcase
        return res;
    endfunction

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      acc_q, acc_d;
    logic [SHAMT_BITS-1:0] cnt_q, cnt_d;
    logic [1:0]            op_q, op_d;
    logic                  ready_q, busy_q, done_q;

    // Next-state and datapath update for the sequencer.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d = data_in;
                    cnt_d = shamt;
                    op_d  = op;
                    if (shamt == CNT_ZERO) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // The count guard keeps cnt from wrapping even if SHIFT were
                // somehow entered with a zero count.
                if (cnt_q != CNT_ZERO) begin
                    acc_d = step_one(op_q, acc_q);
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    cnt_d = CNT_ZERO;
                end
                if (cnt_q <= CNT_ONE) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; handshake outputs are registered from the next state
    // so they line up exactly with the state they describe.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            acc_q   <= {WIDTH{1'b0}};
            cnt_q   <= CNT_ZERO;
            op_q    <= OP_SLL;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            ready_q <= (state_d == ST_IDLE);
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_DONE);
        end
    end

    assign data_out = acc_q;
    assign ready    = ready_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle shift controller that sequences a single-bit shift stage to perform a full shift by a 5-bit amount, one bit position per clock. It serves as the low-area alternative to a 32-bit barrel shifter in the processor's execute stage. It accepts one operation at a time through a start/ready handshake and reports completion with a single-cycle done pulse. The result is held until the next operation is accepted.

## Interface
Parameters:
- WIDTH, 32, datapath width in bits.
- SHAMT_BITS, 5, shift-amount width; must satisfy 2^SHAMT_BITS >= WIDTH.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears all state on the rising edge where it is high.
- start  input  1  request; accepted only when ready=1.
- op  input  2  operation: 00 sll, 01 srl (zero fill), 10 sra (sign fill), 11 rotate left.
- data_in  input  WIDTH  operand; sampled on the accepting edge.
- shamt  input  SHAMT_BITS  shift amount, 0..WIDTH-1; sampled on the accepting edge.
- data_out  output  WIDTH  result register.
- ready  output  1  high in IDLE only.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse; data_out is valid from this cycle on.

## Operation
- Internal registers:
  - acc (WIDTH): drives data_out.
  - cnt (SHAMT_BITS): remaining shift count.
  - op_q (2): latched operation.
  - state (2 bits): IDLE, SHIFT, DONE.
- Single-bit step applied to acc, per op_q:
  - sll: {acc[W-2:0], 0}
  - srl: {0, acc[W-1:1]}
  - sra: {acc[W-1], acc[W-1:1]}
  - rol: {acc[W-2:0], acc[W-1]}
- IDLE:
  - ready=1, busy=0, done=0.
  - On start=1: acc<=data_in, cnt<=shamt, op_q<=op.
  - Next state is DONE if shamt==0, otherwise SHIFT.
  - With start=0: all registers hold.
- SHIFT:
  - Every cycle: acc<=step(acc), cnt<=cnt-1.
  - When cnt==1 (final step), next state is DONE; otherwise stay in SHIFT.
  - cnt never wraps below 0.
- DONE:
  - done=1 for exactly one cycle; acc holds.
  - Next state is IDLE unconditionally.
- Ignored input: start while busy is dropped, not queued. data_in, shamt and op are don't-care outside the accepting edge.
- Hold behaviour: data_out keeps the last result in IDLE until the next accepted start overwrites acc.
- Back-to-back: start asserted in the IDLE cycle immediately after DONE is accepted normally.
- Reset:
  - state=IDLE, acc=0, cnt=0, op_q=00.
  - Outputs after reset: data_out=0, ready=1, busy=0, done=0.
  - Reset takes priority over start on the same edge.
  - Reset asserted mid-SHIFT aborts the operation; no done pulse is produced.

## Timing
- Accepting edge is edge 0, where start=1 and ready=1.
- shamt=N>0: SHIFT occupies cycles 1..N; done=1 in cycle N+1; ready returns in cycle N+2.
- shamt=0: done=1 in cycle 1; ready in cycle 2.
- Worst case (shamt=31): done in cycle 32; minimum issue interval is 33 cycles.
- Outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

## Test plan
- Reset: assert reset for 2 cycles -> data_out=0x00000000, ready=1, busy=0, done=0.
- sll: op=00, data_in=0x0000000F, shamt=4 -> done in cycle 5 with data_out=0x000000F0; ready=1 in cycle 6.
- sra/srl: op=10, data_in=0x80000000, shamt=31 -> done in cycle 32 with data_out=0xFFFFFFFF. Repeat with op=01 -> data_out=0x00000001.
- Rotate and zero shift:
  - op=11, data_in=0x80000001, shamt=1 -> data_out=0x00000003, done in cycle 2.
  - shamt=0 -> data_out=data_in, done in cycle 1.
- Start while busy: start again during SHIFT with different operands -> ignored; first result unaffected; exactly one done pulse.
- Reset mid-operation: reset at cycle 3 of a shamt=10 sll -> no done pulse, data_out=0, ready=1. A new start on the next edge is accepted and completes correctly.
